// File: rtl/dram_req_sequencer.sv
// dram_req_sequencer: open-row DRAM request sequencer with per-bank row tracking.
// Optional periodic refresh is enabled by defining DRAM_SEQ_REFRESH_EN.
module dram_req_sequencer #(
  parameter int NUM_OF_BANKS     = 8,
  parameter int NUM_OF_ROWS      = 128,
  parameter int NUM_OF_COLS      = 8,
  parameter int DATA_WIDTH       = 1,
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int REFRESH_INTERVAL = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] req_bank,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  req_row,
  input  logic [$clog2(NUM_OF_COLS)-1:0]  req_col,
  input  logic [DATA_WIDTH-1:0]           req_wdata,
  output logic                            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            bank_rw,
  output logic                            buffer_rw,
  output logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  rowid,
  output logic [$clog2(NUM_OF_COLS)-1:0]  colid,
  output logic [DATA_WIDTH-1:0]           dram_wdata,
  input  logic [DATA_WIDTH-1:0]           dram_rdata
);
  localparam int RW = $clog2(NUM_OF_ROWS);
  typedef enum logic [2:0] {
    IDLE, PRECHARGE, ACTIVATE, ACCESS, READ_WAIT
`ifdef DRAM_SEQ_REFRESH_EN
    , REFRESH
`endif
  } state_t;
  state_t                  state;
  logic [3:0]              cnt;
  logic                    wr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [NUM_OF_BANKS-1:0] vld;
  logic [RW-1:0]           row_tab [NUM_OF_BANKS];
  logic                    accept;
  logic                    hit;
`ifdef DRAM_SEQ_REFRESH_EN
  logic [15:0] rcnt;
  logic        pending;
  logic        wrap;
  assign wrap      = rcnt == 16'(REFRESH_INTERVAL - 1);
  assign req_ready = state == IDLE && !pending;
`else
  // interval only matters with refresh compiled in; the term folds to 1
  assign req_ready = state == IDLE && REFRESH_INTERVAL > 0;
`endif
  assign accept = req_valid && req_ready;
  assign hit    = vld[req_bank] && row_tab[req_bank] == req_row;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr         <= 1'b0;
      wdata      <= '0;
      vld        <= '0;
      bank_rw    <= 1'b0;
      buffer_rw  <= 1'b0;
      bank_id    <= '0;
      rowid      <= '0;
      colid      <= '0;
      dram_wdata <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
`ifdef DRAM_SEQ_REFRESH_EN
      rcnt       <= '0;
      pending    <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef DRAM_SEQ_REFRESH_EN
      rcnt <= wrap ? '0 : rcnt + 1'b1;
      if (wrap) pending <= 1'b1;
`endif
      case (state)
        IDLE:
          if (accept) begin
            wr      <= req_write;
            wdata   <= req_wdata;
            bank_id <= req_bank;
            rowid   <= req_row;
            colid   <= req_col;
            if (hit) begin
              state      <= ACCESS;
              bank_rw    <= req_write;
              buffer_rw  <= !req_write;
              dram_wdata <= req_write ? req_wdata : '0;
            end else if (vld[req_bank]) begin
              state <= PRECHARGE;
              cnt   <= 4'(T_RP - 1);
            end else begin
              state <= ACTIVATE;
              cnt   <= 4'(T_RCD - 1);
            end
          end
`ifdef DRAM_SEQ_REFRESH_EN
          // refresh starts on the wrap edge itself so ready drops for exactly T_RP cycles
          else if (pending || wrap) begin
            state   <= REFRESH;
            cnt     <= 4'(T_RP - 1);
            pending <= 1'b0;
          end
`endif
        PRECHARGE:
          if (cnt == 4'd0) begin
            vld[bank_id] <= 1'b0;
            state        <= ACTIVATE;
            cnt          <= 4'(T_RCD - 1);
          end else cnt <= cnt - 1'b1;
        ACTIVATE:
          if (cnt == 4'd0) begin
            vld[bank_id]     <= 1'b1;
            row_tab[bank_id] <= rowid;
            state            <= ACCESS;
            bank_rw          <= wr;
            buffer_rw        <= !wr;
            dram_wdata       <= wr ? wdata : '0;
          end else cnt <= cnt - 1'b1;
        ACCESS: begin
          bank_rw    <= 1'b0;
          buffer_rw  <= 1'b0;
          dram_wdata <= '0;
          state      <= wr ? IDLE : READ_WAIT;
        end
        READ_WAIT: begin
          rsp_rdata <= dram_rdata;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
`ifdef DRAM_SEQ_REFRESH_EN
        REFRESH:
          if (cnt == 4'd0) begin
            vld   <= '0;
            state <= IDLE;
          end else cnt <= cnt - 1'b1;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dram_req_sequencer.md
DRAM_REQ_SEQUENCER -- requirements
Module: dram_req_sequencer

Interface
REQ-001 SHALL have parameter NUM_OF_BANKS, default 8: number of banks.
REQ-002 SHALL have parameter NUM_OF_ROWS, default 128: rows per bank.
REQ-003 SHALL have parameter NUM_OF_COLS, default 8: columns per row.
REQ-004 SHALL have parameter DATA_WIDTH, default 1: data bits per cell.
REQ-005 SHALL have parameter T_RCD, default 2: activate-to-access cycles, legal range 1..15.
REQ-006 SHALL have parameter T_RP, default 2: precharge cycles, legal range 1..15.
REQ-007 SHALL have parameter REFRESH_INTERVAL, default 256: cycles between refreshes, legal range 16..65535.
REQ-008 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-009 SHALL have req_valid in 1, req_ready out 1: host request handshake.
REQ-010 SHALL have req_write in 1: 1 = write, 0 = read.
REQ-011 SHALL have req_bank in clog2(NUM_OF_BANKS), req_row in clog2(NUM_OF_ROWS), req_col in clog2(NUM_OF_COLS): target address.
REQ-012 SHALL have req_wdata in DATA_WIDTH: write data.
REQ-013 SHALL have rsp_valid out 1, rsp_rdata out DATA_WIDTH: read response.
REQ-014 SHALL have bank_rw out 1, buffer_rw out 1, bank_id/rowid/colid out (address widths): DRAM model control.
REQ-015 SHALL have dram_wdata out DATA_WIDTH and dram_rdata in DATA_WIDTH: split DRAM data path.

Function
REQ-016 SHALL implement states IDLE, PRECHARGE, ACTIVATE, ACCESS, READ_WAIT, REFRESH.
REQ-017 SHALL assert req_ready only in IDLE with no refresh pending; a request is accepted when req_valid && req_ready, and all req_* fields are registered at acceptance.
REQ-018 SHALL keep a per-bank open-row table (valid bit + row index), cleared by reset.
REQ-019 On acceptance: row hit -> ACCESS next cycle; bank closed -> ACTIVATE; other row open -> PRECHARGE.
REQ-020 PRECHARGE SHALL last exactly T_RP cycles, invalidate that bank's entry, then go to ACTIVATE.
REQ-021 ACTIVATE SHALL last exactly T_RCD cycles, record the row as open, then go to ACCESS.
REQ-022 ACCESS SHALL last one cycle: write -> bank_rw=1, dram_wdata=registered wdata; read -> buffer_rw=1; then write -> IDLE, read -> READ_WAIT.
REQ-023 READ_WAIT SHALL last one cycle and capture dram_rdata into rsp_rdata; rsp_valid SHALL pulse high for exactly the following cycle.
REQ-024 bank_rw and buffer_rw SHALL never be high together and SHALL be low outside ACCESS; bank_id/rowid/colid SHALL hold the registered address from acceptance until return to IDLE.
REQ-025 Latency (acceptance = cycle 0): hit write strobe cycle 1; closed-bank strobe cycle T_RCD+1; conflict strobe cycle T_RP+T_RCD+1; read rsp_valid at strobe cycle + 2.
REQ-026 rsp_rdata SHALL hold its value until the next read capture.

Reset
REQ-027 With rst high at a clk edge: state=IDLE, open-row table cleared, refresh counter=0, all outputs 0 except req_ready=1 on the first cycle after rst deasserts.
REQ-028 rst asserted mid-operation SHALL abort the operation with no further strobes and no rsp_valid.

Configuration
REQ-029 Macro DRAM_SEQ_REFRESH_EN SHALL gate the refresh feature.
REQ-030 With DRAM_SEQ_REFRESH_EN defined: a counter increments every cycle; at REFRESH_INTERVAL-1 it wraps to 0 and sets refresh-pending; when in IDLE with pending set and no acceptance in that cycle, enter REFRESH for T_RP cycles, clear all open-row entries and pending, then IDLE; an in-flight request completes first.
REQ-031 Without DRAM_SEQ_REFRESH_EN: no counter and no REFRESH state; open rows persist until conflict or reset.

Verification
REQ-032 After reset, write bank 3 row 5 col 2 data 1 -> ACTIVATE 2 cycles, bank_rw=1 at cycle 3 with bank_id=3, rowid=5, colid=2, dram_wdata=1.
REQ-033 Read bank 3 row 5 col 2 immediately after -> hit, buffer_rw=1 at cycle 1, model returns 1, rsp_valid=1 with rsp_rdata=1 at cycle 3.
REQ-034 Write bank 3 row 9 after row 5 is open -> PRECHARGE 2 cycles, ACTIVATE 2 cycles, bank_rw=1 at cycle 5.
REQ-035 rst asserted in cycle 1 of ACTIVATE -> no bank_rw, no rsp_valid, req_ready=1 the cycle after release, next access to that bank takes the closed-bank path.
REQ-036 With DRAM_SEQ_REFRESH_EN, REFRESH_INTERVAL=16: open bank 0 row 1, idle 20 cycles -> REFRESH once with req_ready=0 for 2 cycles; next access to bank 0 row 1 takes the closed-bank path (strobe at cycle 3).
